// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            req_we;
   logic [2:0]      req_mem_op;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;

   modport master (
      output req_valid, req_addr, req_wdata, req_we, req_mem_op, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_we, req_mem_op, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data memory: one outstanding request, programmable latency,
// byte-lane stores, sign/zero-extended loads and fault reporting.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid
// BUSY  | latency countdown; access performed when counter reaches 0
// RESP  | response held until resp_ready
module dmem_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          st, nxt;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] cap_addr;
   logic [XLEN-1:0] cap_wdata;
   logic            cap_we;
   logic [2:0]      cap_op;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic [AW-1:0]   word_idx;
   logic            illegal, misaligned, out_of_range, acc_err;
   logic            access, wr_en;
   logic [3:0]      wr_be;
   logic [XLEN-1:0] wr_word, rd_word, rd_shift, ld_val;

   always_ff @(posedge clk) begin
      if (reset) st <= IDLE;
      else       st <= nxt;
   end

   always_comb begin
      nxt = st;
      case (st)
         IDLE:    if (bus.req_valid)  nxt = BUSY;
         BUSY:    if (cnt == '0)      nxt = RESP;
         RESP:    if (bus.resp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (st)
         IDLE:    bus.req_ready  = 1'b1;
         RESP:    bus.resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // Fault priority: illegal op, then misalignment, then range.
   assign word_idx     = cap_addr[AW+1:2];
   assign illegal      = (cap_op == 3'b011) || (cap_op[2:1] == 2'b11) || (cap_op[2] && cap_we);
   assign misaligned   = ((cap_op[1:0] == 2'b01) && cap_addr[0]) ||
                         ((cap_op[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
   assign out_of_range = |cap_addr[XLEN-1:AW+2];
   assign acc_err      = illegal || misaligned || out_of_range;
   assign access       = (st == BUSY) && (cnt == '0);
   assign wr_en        = access && cap_we && !acc_err && !reset;

   always_comb begin
      wr_be   = 4'b0000;
      wr_word = cap_wdata;
      case (cap_op[1:0])
         2'b00: begin
            wr_be   = 4'b0001 << cap_addr[1:0];
            wr_word = {4{cap_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{cap_wdata[15:0]}};
         end
         default: wr_be = 4'b1111;
      endcase
   end

   assign rd_word  = mem[word_idx];
   assign rd_shift = rd_word >> {cap_addr[1:0], 3'b000};

   always_comb begin
      ld_val = '0;
      case (cap_op)
         3'b000:  ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  ld_val = rd_word;
         3'b100:  ld_val = {24'b0, rd_shift[7:0]};
         3'b101:  ld_val = {16'b0, rd_shift[15:0]};
         default: ld_val = '0;
      endcase
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_we    <= 1'b0;
         cap_op    <= 3'b000;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (st)
            IDLE: if (bus.req_valid) begin
               cap_addr  <= bus.req_addr;
               cap_wdata <= bus.req_wdata;
               cap_we    <= bus.req_we;
               cap_op    <= bus.req_mem_op;
               cnt       <= CW'(LATENCY - 1);
            end
            BUSY: if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               rdata_q <= (acc_err || cap_we) ? '0 : ld_val;
               err_q   <= acc_err;
            end
            RESP: if (bus.resp_ready) begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
